// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multi-cycle RV32I control FSM (lw, sw, R, I, beq, jal) driving a shared ALU/memory datapath.
// Ports: clk, rst_n (async active-low); op/funct3/funct7 from IR; zero from ALU; mem_ready handshake;
// outputs mem_req, mem_write, adr_src, ir_write, pc_write, reg_write, alu_src_a/b, result_src, imm_src,
// alu_control, retire pulse, retire_count, sticky illegal. Define MCTRL_BNE_EN to also accept bne.
module multicycle_ctrl #(
  parameter int ALU_CTRL_W = 3,
  parameter int RETIRE_W   = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [6:0]            op,
  input  logic [2:0]            funct3,
  input  logic                  funct7,
  input  logic                  zero,
  input  logic                  mem_ready,
  output logic                  mem_req,
  output logic                  mem_write,
  output logic                  adr_src,
  output logic                  ir_write,
  output logic                  pc_write,
  output logic                  reg_write,
  output logic [1:0]            alu_src_a,
  output logic [1:0]            alu_src_b,
  output logic [1:0]            result_src,
  output logic [1:0]            imm_src,
  output logic [ALU_CTRL_W-1:0] alu_control,
  output logic                  retire,
  output logic [RETIRE_W-1:0]   retire_count,
  output logic                  illegal
);
  typedef enum logic [3:0] {
    IDLE, FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
    EXECR, EXECI, ALUWB, BEQ, JAL, TRAP
  } state_t;
  state_t state, next;
  logic [1:0] alu_op;
  logic [2:0] alu_code;
  logic [1:0] op_imm;
  logic       branch_ok;
  logic       branch_taken;
`ifdef MCTRL_BNE_EN
  assign branch_ok    = funct3 == 3'b000 || funct3 == 3'b001;
  assign branch_taken = funct3[0] ? ~zero : zero;
`else
  assign branch_ok    = funct3 == 3'b000;
  assign branch_taken = zero;
`endif
  assign op_imm = op == 7'b0100011 ? 2'b01 :
                  op == 7'b1100011 ? 2'b10 :
                  op == 7'b1101111 ? 2'b11 : 2'b00;
  always_comb begin
    alu_code = alu_op == 2'b00 ? 3'b000 :
               alu_op == 2'b01 ? 3'b001 :
               funct3 == 3'b000 ? ((op[5] & funct7) ? 3'b001 : 3'b000) :
               funct3 == 3'b010 ? 3'b101 :
               funct3 == 3'b110 ? 3'b110 :
               funct3 == 3'b111 ? 3'b010 : 3'b000;
  end
  assign alu_control = ALU_CTRL_W'(alu_code);
  always_comb begin
    next       = state;
    mem_req    = 1'b0;
    mem_write  = 1'b0;
    adr_src    = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    result_src = 2'b00;
    imm_src    = 2'b00;
    alu_op     = 2'b00;
    illegal    = 1'b0;
    case (state)
      IDLE: next = FETCH;
      FETCH: begin
        mem_req    = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        ir_write   = mem_ready;
        pc_write   = mem_ready;
        next       = mem_ready ? DECODE : FETCH;
      end
      DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        imm_src   = op_imm;
        next = (op == 7'b0000011 || op == 7'b0100011) ? MEMADR :
               op == 7'b0110011 ? EXECR :
               op == 7'b0010011 ? EXECI :
               (op == 7'b1100011 && branch_ok) ? BEQ :
               op == 7'b1101111 ? JAL : TRAP;
      end
      MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        imm_src   = op_imm;
        next      = op[5] ? MEMWRITE : MEMREAD;
      end
      MEMREAD: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
        next    = mem_ready ? MEMWB : MEMREAD;
      end
      MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
        next       = FETCH;
      end
      MEMWRITE: begin
        mem_req   = 1'b1;
        mem_write = 1'b1;
        adr_src   = 1'b1;
        next      = mem_ready ? FETCH : MEMWRITE;
      end
      EXECR: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b10;
        next      = ALUWB;
      end
      EXECI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = 2'b10;
        next      = ALUWB;
      end
      ALUWB: begin
        reg_write = 1'b1;
        next      = FETCH;
      end
      BEQ: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b01;
        pc_write  = branch_taken;
        next      = FETCH;
      end
      JAL: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_write  = 1'b1;
        next      = ALUWB;
      end
      TRAP: illegal = 1'b1;
      default: next = IDLE;
    endcase
  end
  // FETCH->FETCH is a wait stall and IDLE->FETCH is the post-reset start, neither completes an instruction
  assign retire = next == FETCH && state != IDLE && state != FETCH;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      retire_count <= '0;
    end else begin
      state <= next;
      if (retire) retire_count <= retire_count + 1'b1;
    end
  end
endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multi-cycle control unit for the RV32I subset core: lw, sw, R-type, I-type ALU, beq, jal.
- Replaces the per-instruction decoder with a state machine that drives a shared-ALU/shared-memory datapath over several cycles.
- Adds a memory request/ready handshake with wait states, a retired-instruction counter, and a sticky illegal-instruction trap.
- Sits between the instruction register (op/funct3/funct7 inputs) and the datapath muxes and write enables.

Parameters:
- ALU_CTRL_W, 3, width of alu_control. Must be >= 3; codes are zero-extended.
- RETIRE_W, 32, width of retire_count.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- op  in  7  opcode from instruction register; stable from DECODE to end of instruction.
- funct3  in  3  instr[14:12].
- funct7  in  1  instr[30].
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completes the current request this cycle.
- mem_req  out  1  memory request.
- mem_write  out  1  write qualifier for mem_req.
- adr_src  out  1  memory address select: 0 = PC, 1 = ALU-out register.
- ir_write  out  1  load instruction register and oldPC.
- pc_write  out  1  load PC from result.
- reg_write  out  1  register file write.
- alu_src_a  out  2  00 PC, 01 oldPC, 10 rs1 data.
- alu_src_b  out  2  00 rs2 data, 01 immediate, 10 constant 4.
- result_src  out  2  00 ALU-out register, 01 read data, 10 ALU result.
- imm_src  out  2  00 I, 01 S, 10 B, 11 J.
- alu_control  out  ALU_CTRL_W  000 add, 001 sub, 010 and, 110 or, 101 slt.
- retire  out  1  one-cycle pulse when an instruction completes.
- retire_count  out  RETIRE_W  count of retired instructions.
- illegal  out  1  sticky trap indicator.

Behaviour:
- Reset: asynchronous on rst_n low. State = IDLE, retire_count = 0. Every output is 0 while in IDLE.
- Outputs are decoded combinationally from the state register. Exceptions: pc_write in BEQ depends on zero; strobes in memory states are gated by mem_ready as stated below.
- Unlisted outputs in any state are 0. alu_op is internal: 00 add, 01 sub, 10 funct decode.
- IDLE -> FETCH unconditionally. Gives one idle cycle after reset release.
- FETCH: mem_req=1, adr_src=0, alu_src_a=00, alu_src_b=10, alu_op=00, result_src=10.
  - If mem_ready: ir_write=1, pc_write=1, go to DECODE.
  - Otherwise stay in FETCH with ir_write=0 and pc_write=0.
- DECODE: alu_src_a=01, alu_src_b=01, alu_op=00; imm_src from op.
  - lw (0000011) or sw (0100011) -> MEMADR.
  - R-type (0110011) -> EXECR.
  - I-type (0010011) -> EXECI.
  - branch (1100011) with funct3=000 -> BEQ.
  - jal (1101111) -> JAL.
  - Any other op -> TRAP.
- MEMADR: alu_src_a=10, alu_src_b=01, alu_op=00, imm_src from op. Goes to MEMREAD if op[5]=0, MEMWRITE if op[5]=1.
- MEMREAD: mem_req=1, adr_src=1, result_src=00. Goes to MEMWB on mem_ready; otherwise holds.
- MEMWB: result_src=01, reg_write=1 -> FETCH.
- MEMWRITE: mem_req=1, mem_write=1, adr_src=1, result_src=00. Goes to FETCH on mem_ready; otherwise holds.
- EXECR: alu_src_a=10, alu_src_b=00, alu_op=10 -> ALUWB.
- EXECI: alu_src_a=10, alu_src_b=01, alu_op=10 -> ALUWB.
- ALUWB: result_src=00, reg_write=1 -> FETCH.
- BEQ: alu_src_a=10, alu_src_b=00, alu_op=01, result_src=00, pc_write=zero -> FETCH.
- JAL: alu_src_a=01, alu_src_b=10, alu_op=00, result_src=00, pc_write=1 -> ALUWB.
- TRAP: illegal=1, all other outputs 0. Stays in TRAP until reset.
- ALU decode when alu_op=10:
  - funct3 000 -> sub if (op[5] & funct7), else add.
  - funct3 010 -> slt; 110 -> or; 111 -> and.
  - Any other funct3 -> add.
- Retire:
  - retire=1 on every transition into FETCH except IDLE->FETCH.
  - retire_count increments on the same edge and wraps modulo 2^RETIRE_W.
- Latencies in cycles, zero wait states, FETCH through last state:
  - lw 5; sw 4; R/I 4; beq 3; jal 4.
  - Each wait cycle adds 1.
- mem_ready outside FETCH, MEMREAD or MEMWRITE is ignored.
- Reset asserted mid-instruction aborts it immediately: no retire, count cleared.

Optional Feature:
- Macro: MCTRL_BNE_EN.
- Defined: branch op with funct3=001 (bne) goes to BEQ state with pc_write = ~zero. Funct3 000 behaves as beq.
- Undefined: branch op with any funct3 other than 000 goes to TRAP.

Test Plan:
- Reset release, mem_ready=1, op=0110011, funct3=000, funct7=1 -> IDLE, FETCH(ir_write=1, pc_write=1), DECODE, EXECR(alu_control=001), ALUWB(reg_write=1); retire pulse; retire_count=1.
- lw (0000011) with mem_ready low 2 cycles in FETCH and 3 cycles in MEMREAD -> mem_req held high; ir_write only on the ready cycle; MEMWB reg_write=1, result_src=01; total 10 cycles.
- beq with zero=1 then zero=0 -> pc_write=1 in BEQ, then pc_write=0; both retire; alu_control=001.
- jal -> JAL pc_write=1, alu_src_a=01, alu_src_b=10, then ALUWB reg_write=1; imm_src=11 in DECODE.
- op=1111111 -> TRAP; illegal=1 stays set over 20 cycles; no mem_req, no retire; rst_n low clears illegal.
- RETIRE_W=4: 17 addi instructions -> retire_count wraps to 1. Branch funct3=001: TRAP without MCTRL_BNE_EN; with it, pc_write=~zero.
